// File: rtl/rtc_display_loader.sv
// Per-frame RTC sweep: reads nine BCD registers over a req/ack port into a working
// buffer, then commits date, time and timer digits to the overlay in a single cycle.
module rtc_display_loader #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        hold,
  output logic        rd_req,
  output logic [7:0]  rd_addr,
  input  logic        rd_ack,
  input  logic [7:0]  rd_data,
  output logic        busy,
  output logic        frame_done,
  output logic [23:0] fecha,
  output logic [23:0] hora,
  output logic [23:0] timer,
  output logic        err_timeout,
  output logic        err_bcd
);

  typedef enum logic [1:0] {IDLE, REQ, NEXT, COMMIT} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [3:0] LAST_IDX  = 4'd8;

  // Buffer slots: 0 sec, 1 min, 2 hour, 3 day, 4 month, 5 year, 6..8 timer sec/min/hour.
  function automatic logic [7:0] reg_addr(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h21;
      4'd1:    return 8'h22;
      4'd2:    return 8'h23;
      4'd3:    return 8'h24;
      4'd4:    return 8'h25;
      4'd5:    return 8'h26;
      4'd6:    return 8'h41;
      4'd7:    return 8'h42;
      4'd8:    return 8'h43;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic bcd_ok(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  wait_q, wait_d;
  logic        rd_req_q, rd_req_d;
  logic [7:0]  rd_addr_q, rd_addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [23:0] fecha_q, fecha_d;
  logic [23:0] hora_q, hora_d;
  logic [23:0] timer_q, timer_d;
  logic        err_to_q, err_to_d;
  logic        err_bcd_q, err_bcd_d;
  logic [7:0]  work_q [9];
  logic [7:0]  work_d [9];

  always_comb begin
    // NOTE: every signal gets its hold value first so no branch can leave one unassigned (no latches).
    state_d   = state_q;
    idx_d     = idx_q;
    wait_d    = wait_q;
    rd_addr_d = rd_addr_q;
    fecha_d   = fecha_q;
    hora_d    = hora_q;
    timer_d   = timer_q;
    err_to_d  = err_to_q;
    err_bcd_d = err_bcd_q;
    work_d    = work_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_start && !hold) begin
          {work_d[2], work_d[1], work_d[0]} = hora_q;
          {work_d[3], work_d[4], work_d[5]} = fecha_q;
          {work_d[8], work_d[7], work_d[6]} = timer_q;
          idx_d   = 4'd0;
          wait_d  = 8'd0;
          state_d = REQ;
        end
      end
      REQ: begin
        // An ack arriving on the final allowed cycle still counts as a good read.
        if (rd_ack) begin
          if (bcd_ok(rd_data)) work_d[idx_q] = rd_data;
          else                 err_bcd_d     = 1'b1;
          state_d = NEXT;
        end else if (wait_q + 8'd1 == TIMEOUT_C) begin
          err_to_d = 1'b1;
          state_d  = NEXT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      NEXT: begin
        wait_d = 8'd0;
        if (idx_q == LAST_IDX) begin
          state_d = COMMIT;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = REQ;
        end
      end
      COMMIT: begin
        hora_d  = {work_q[2], work_q[1], work_q[0]};
        fecha_d = {work_q[3], work_q[4], work_q[5]};
        timer_d = {work_q[8], work_q[7], work_q[6]};
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Port-facing flags are derived from the next state so they are registered yet aligned.
    rd_req_d = (state_d == REQ);
    busy_d   = (state_d != IDLE);
    if (state_d == REQ) rd_addr_d = reg_addr(idx_d);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= 4'd0;
      wait_q    <= 8'd0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fecha_q   <= 24'h0;
      hora_q    <= 24'h0;
      timer_q   <= 24'h0;
      err_to_q  <= 1'b0;
      err_bcd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wait_q    <= wait_d;
      rd_req_q  <= rd_req_d;
      rd_addr_q <= rd_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fecha_q   <= fecha_d;
      hora_q    <= hora_d;
      timer_q   <= timer_d;
      err_to_q  <= err_to_d;
      err_bcd_q <= err_bcd_d;
    end
  end

  // NOTE: the working buffer is not reset; it is always reloaded from the committed outputs before use.
  always_ff @(posedge clk) begin
    work_q <= work_d;
  end

  assign rd_req      = rd_req_q;
  assign rd_addr     = rd_addr_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign fecha       = fecha_q;
  assign hora        = hora_q;
  assign timer       = timer_q;
  assign err_timeout = err_to_q;
  assign err_bcd     = err_bcd_q;

endmodule
